load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 28 ++
 rtl/load_store_unit.sv | 77 +++++++
 tb/tb_load_store_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: core request/response channel plus the word-wide data-memory port.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_rdata;
  logic                  resp_fault;
  logic                  mem_wEn;
  logic [ADDR_WIDTH-1:0] mem_d_address;
  logic [DATA_WIDTH-1:0] mem_d_write_data;
  logic [DATA_WIDTH-1:0] mem_d_read_data;
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_d_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_fault, mem_wEn, mem_d_address, mem_d_write_data
  );
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_d_read_data,
    output req_ready, resp_valid, resp_rdata, resp_fault, mem_wEn, mem_d_address, mem_d_write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I byte/half/word loads and stores over a combinational-read word memory;
// sub-word stores are done as read-modify-write.
module load_store_unit #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input logic              clock,
  input logic              reset_n,
  load_store_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;
  state_t                  state, state_nx;
  logic                    we;
  logic [2:0]              funct3;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [31:0]             rdata;
  logic                    fault_q;
  logic                    accept, illegal, misaligned, fault, sub_word;
  logic [4:0]              shamt;
  logic [31:0]             shifted, load_val, lane_mask, lane_data, merged;
  assign accept     = bus.req_valid && state == IDLE;
  assign illegal    = bus.req_we ? (bus.req_funct3[2] || bus.req_funct3[1:0] == 2'b11)
                                 : (bus.req_funct3 == 3'b011 || bus.req_funct3[2:1] == 2'b11);
  assign misaligned = (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
                      (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
  assign fault      = illegal || misaligned;
  assign sub_word   = funct3[1:0] != 2'b10;
  assign shamt      = {addr[1:0], 3'b000};
  assign shifted    = bus.mem_d_read_data >> shamt;
  // funct3[2] selects zero extension for LBU/LHU
  assign load_val   = funct3[1] ? shifted
                    : funct3[0] ? {{16{~funct3[2] & shifted[15]}}, shifted[15:0]}
                    : {{24{~funct3[2] & shifted[7]}}, shifted[7:0]};
  assign lane_mask  = (funct3[0] ? 32'h0000_FFFF : 32'h0000_00FF) << shamt;
  assign lane_data  = funct3[0] ? {2{wr_data[15:0]}} : {4{wr_data[7:0]}};
  assign merged     = (bus.mem_d_read_data & ~lane_mask) | (lane_data & lane_mask);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? (fault ? RESP : ACCESS) : IDLE;
      ACCESS:  state_nx = (we && sub_word) ? WRITE : RESP;
      WRITE:   state_nx = RESP;
      default: state_nx = bus.resp_ready ? IDLE : RESP;
    endcase
  end
  // wr_data doubles as the write-data register: store data on accept, merged word for SB/SH
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      we      <= 1'b0;
      funct3  <= 3'b000;
      addr    <= '0;
      wr_data <= '0;
      rdata   <= 32'h0;
      fault_q <= 1'b0;
    end else if (accept) begin
      we      <= bus.req_we;
      funct3  <= bus.req_funct3;
      addr    <= bus.req_addr[ADDR_WIDTH-1:0];
      wr_data <= bus.req_wdata;
      rdata   <= 32'h0;
      fault_q <= fault;
    end else if (state == ACCESS) begin
      if (!we) rdata <= load_val;
      else if (sub_word) wr_data <= merged;
    end
  assign bus.req_ready        = state == IDLE;
  assign bus.resp_valid       = state == RESP;
  assign bus.resp_rdata       = rdata;
  assign bus.resp_fault       = fault_q;
  assign bus.mem_wEn          = state == WRITE || (state == ACCESS && we && !sub_word);
  assign bus.mem_d_address    = {addr[ADDR_WIDTH-1:2], 2'b00};
  assign bus.mem_d_write_data = wr_data;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of load formatting, store merging, faults, backpressure and reset.
module tb_load_store_unit;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] mem [0:255];
  load_store_unit_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();
  load_store_unit #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  always #5 clock = ~clock;
  assign bus.mem_d_read_data = mem[bus.mem_d_address[9:2]];
  always @(posedge clock) if (bus.mem_wEn) mem[bus.mem_d_address[9:2]] <= bus.mem_d_write_data;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic issue(input logic we, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    check("req_ready_idle", {31'b0, bus.req_ready}, 32'd1);
    bus.req_we = we;
    bus.req_funct3 = f;
    bus.req_addr = a;
    bus.req_wdata = d;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
  endtask
  task automatic handshake();
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    check("idle_after_hs", {30'b0, bus.req_ready, bus.resp_valid}, 32'b10);
  endtask
  task automatic load(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] exp);
    issue(1'b0, f, a, 32'h0);
    check({tag, "_n1_valid"}, {31'b0, bus.resp_valid}, 32'd0);
    step();
    check({tag, "_valid"}, {31'b0, bus.resp_valid}, 32'd1);
    check({tag, "_rdata"}, bus.resp_rdata, exp);
    check({tag, "_fault"}, {31'b0, bus.resp_fault}, 32'd0);
    handshake();
  endtask
  task automatic faulting(input string tag, input logic we, input logic [2:0] f, input logic [31:0] a);
    issue(we, f, a, 32'hFFFF_FFFF);
    check({tag, "_valid"}, {31'b0, bus.resp_valid}, 32'd1);
    check({tag, "_fault"}, {31'b0, bus.resp_fault}, 32'd1);
    check({tag, "_rdata"}, bus.resp_rdata, 32'h0);
    check({tag, "_wen"}, {31'b0, bus.mem_wEn}, 32'd0);
    handshake();
  endtask
  task automatic sub_store(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] word);
    issue(1'b1, f, a, d);
    check({tag, "_access_wen"}, {31'b0, bus.mem_wEn}, 32'd0);
    step();
    check({tag, "_write_wen"}, {31'b0, bus.mem_wEn}, 32'd1);
    check({tag, "_wdata"}, bus.mem_d_write_data, word);
    check({tag, "_addr"}, {16'b0, bus.mem_d_address}, {a[31:2], 2'b00} & 32'hFFFF);
    check({tag, "_n2_valid"}, {31'b0, bus.resp_valid}, 32'd0);
    step();
    check({tag, "_resp"}, {30'b0, bus.resp_valid, bus.mem_wEn}, 32'b10);
    check({tag, "_rdata"}, bus.resp_rdata, 32'h0);
    handshake();
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h40] = 32'h8899_AABB;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    bus.resp_ready = 1'b0;
    #12;
    check("rst_resp", {bus.resp_rdata[29:0], bus.resp_valid, bus.resp_fault}, 32'h0);
    check("rst_mem", {15'b0, bus.mem_wEn, bus.mem_d_address}, 32'h0);
    check("rst_wdata", bus.mem_d_write_data, 32'h0);
    step();
    reset_n = 1'b1;
    step();
    check("ready_after_rst", {31'b0, bus.req_ready}, 32'd1);
    // LB with backpressure held for three cycles
    issue(1'b0, 3'b000, 32'h0000_0101, 32'h0);
    check("lb_addr", {16'b0, bus.mem_d_address}, 32'h0100);
    check("lb_n1_valid", {31'b0, bus.resp_valid}, 32'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      check("hold_valid", {31'b0, bus.resp_valid}, 32'd1);
      check("hold_rdata", bus.resp_rdata, 32'hFFFF_FFAA);
      check("hold_ready", {31'b0, bus.req_ready}, 32'd0);
      step();
    end
    handshake();
    load("lbu", 3'b100, 32'h0000_0101, 32'h0000_00AA);
    load("lh", 3'b001, 32'h0000_0102, 32'hFFFF_8899);
    load("lhu", 3'b101, 32'h0000_0102, 32'h0000_8899);
    load("lb_pos", 3'b000, 32'h0000_0100, 32'hFFFF_FFBB);
    load("lw", 3'b010, 32'h0000_0100, 32'h8899_AABB);
    sub_store("sh", 3'b001, 32'h0000_0102, 32'h0000_1234, 32'h1234_AABB);
    load("lw_after_sh", 3'b010, 32'h0000_0100, 32'h1234_AABB);
    sub_store("sb", 3'b000, 32'h0000_0103, 32'hFFFF_FF55, 32'h5534_AABB);
    load("lw_after_sb", 3'b010, 32'h0000_0100, 32'h5534_AABB);
    // SW writes straight from ACCESS
    issue(1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF);
    check("sw_wen", {31'b0, bus.mem_wEn}, 32'd1);
    check("sw_wdata", bus.mem_d_write_data, 32'hDEAD_BEEF);
    check("sw_addr", {16'b0, bus.mem_d_address}, 32'h0104);
    step();
    check("sw_resp", {30'b0, bus.resp_valid, bus.mem_wEn}, 32'b10);
    handshake();
    load("lw_high_bits", 3'b010, 32'hABCD_0104, 32'hDEAD_BEEF);
    faulting("lw_mis", 1'b0, 3'b010, 32'h0000_0006);
    faulting("ld_f011", 1'b0, 3'b011, 32'h0000_0100);
    faulting("lh_mis", 1'b0, 3'b001, 32'h0000_0101);
    faulting("sh_mis", 1'b1, 3'b001, 32'h0000_0103);
    faulting("st_f100", 1'b1, 3'b100, 32'h0000_0100);
    // reset while the SB merge is being written back
    issue(1'b1, 3'b000, 32'h0000_0100, 32'h0000_0077);
    step();
    check("rst_sb_write_wen", {31'b0, bus.mem_wEn}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_sb_wen_drop", {31'b0, bus.mem_wEn}, 32'd0);
    check("rst_sb_valid", {31'b0, bus.resp_valid}, 32'd0);
    step();
    reset_n = 1'b1;
    step();
    check("rst_sb_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst_sb_no_resp", {31'b0, bus.resp_valid}, 32'd0);
    step();
    check("rst_sb_idle", {30'b0, bus.req_ready, bus.resp_valid}, 32'b10);
    load("lw_after_rst", 3'b010, 32'h0000_0100, 32'h5534_AABB);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
